// File: rtl/wavegen_pkg.sv
// Shared constants and types for the summing wave generator configuration controller.
package wavegen_pkg;

    localparam int NCHAN_DEF = 64;
    localparam int WIDTH_DEF = 16;

    localparam logic [1:0] SEL_AMP    = 2'd0;
    localparam logic [1:0] SEL_OFFSET = 2'd1;
    localparam logic [1:0] SEL_PHASE  = 2'd2;
    localparam logic [1:0] SEL_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    // Counter width able to count 0 .. max(a,b)-1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/wavegen_cfg_bank.sv
// One configuration field: per-channel shadow words written by the host and
// active words copied from the shadow in a single cycle on commit.
module wavegen_cfg_bank
    import wavegen_pkg::*;
#(
    parameter int NCHAN = NCHAN_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHW   = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en_i,
    input  logic                   wr_bcast_i,
    input  logic [CHW-1:0]         wr_chan_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   commit_i,
    output logic [NCHAN*WIDTH-1:0] active_o
);

    logic [WIDTH-1:0] shadow_q [NCHAN];
    logic [WIDTH-1:0] active_q [NCHAN];

    // Shadow updates from the host; active copy taken only on commit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NCHAN; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (commit_i) begin
                for (int i = 0; i < NCHAN; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (wr_en_i) begin
                if (wr_bcast_i) begin
                    for (int i = 0; i < NCHAN; i++) begin
                        shadow_q[i] <= wr_data_i;
                    end
                end else begin
                    shadow_q[wr_chan_i] <= wr_data_i;
                end
            end
        end
    end

    for (genvar g = 0; g < NCHAN; g++) begin : g_pack
        assign active_o[g*WIDTH +: WIDTH] = active_q[g];
    end

endmodule

// File: rtl/wavegen_cfg_ctrl.sv
// Configuration controller: shadow/active banks for amplitude, offset and phase
// word, plus the commit sequencer that pulses the generator reset and waits out its pipeline.
module wavegen_cfg_ctrl
    import wavegen_pkg::*;
#(
    parameter int NCHAN         = NCHAN_DEF,
    parameter int WIDTH         = WIDTH_DEF,
    parameter int RESET_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 8,
    parameter int CHW           = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [1:0]             wr_sel,
    input  logic [CHW-1:0]         wr_chan,
    input  logic                   wr_bcast,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   commit,
    output logic [NCHAN*WIDTH-1:0] amps,
    output logic [NCHAN*WIDTH-1:0] offsets,
    output logic [NCHAN*WIDTH-1:0] phasewords,
    output logic                   gen_reset,
    output logic                   busy,
    output logic                   dirty,
    output logic                   commit_done
);

    localparam int CW          = cnt_width(RESET_CYCLES, SETTLE_CYCLES);
    localparam int HOLD_LAST   = (RESET_CYCLES > 1) ? RESET_CYCLES - 1 : 0;
    localparam int SETTLE_LAST = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 0;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          gen_reset_q;
    logic          busy_q;
    logic          dirty_q;
    logic          done_q;

    logic          idle_s;
    logic          wr_fire_s;
    logic          commit_fire_s;

    // Commit wins over a write presented in the same idle cycle.
    assign idle_s        = (state_q == ST_IDLE);
    assign wr_ready      = idle_s && !commit;
    assign wr_fire_s     = wr_valid && wr_ready;
    assign commit_fire_s = idle_s && commit;

    wavegen_cfg_bank #(.NCHAN(NCHAN), .WIDTH(WIDTH), .CHW(CHW)) u_amp_bank (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (wr_fire_s && (wr_sel == SEL_AMP)),
        .wr_bcast_i (wr_bcast),
        .wr_chan_i  (wr_chan),
        .wr_data_i  (wr_data),
        .commit_i   (commit_fire_s),
        .active_o   (amps)
    );

    wavegen_cfg_bank #(.NCHAN(NCHAN), .WIDTH(WIDTH), .CHW(CHW)) u_offset_bank (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (wr_fire_s && (wr_sel == SEL_OFFSET)),
        .wr_bcast_i (wr_bcast),
        .wr_chan_i  (wr_chan),
        .wr_data_i  (wr_data),
        .commit_i   (commit_fire_s),
        .active_o   (offsets)
    );

    wavegen_cfg_bank #(.NCHAN(NCHAN), .WIDTH(WIDTH), .CHW(CHW)) u_phase_bank (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (wr_fire_s && (wr_sel == SEL_PHASE)),
        .wr_bcast_i (wr_bcast),
        .wr_chan_i  (wr_chan),
        .wr_data_i  (wr_data),
        .commit_i   (commit_fire_s),
        .active_o   (phasewords)
    );

    // Commit sequencer: HOLD keeps the generator in reset, SETTLE covers its pipeline.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            gen_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            dirty_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (commit) begin
                        state_q     <= ST_HOLD;
                        cnt_q       <= '0;
                        gen_reset_q <= 1'b1;
                        busy_q      <= 1'b1;
                        dirty_q     <= 1'b0;
                    end else if (wr_fire_s && (wr_sel != SEL_RSVD)) begin
                        dirty_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == CW'(HOLD_LAST)) begin
                        gen_reset_q <= 1'b0;
                        cnt_q       <= '0;
                        if (SETTLE_CYCLES == 0) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_SETTLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == CW'(SETTLE_LAST)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q     <= ST_HOLD;
                    cnt_q       <= '0;
                    gen_reset_q <= 1'b1;
                    busy_q      <= 1'b1;
                end
            endcase
        end
    end

    assign gen_reset   = gen_reset_q;
    assign busy        = busy_q;
    assign dirty       = dirty_q;
    assign commit_done = done_q;

endmodule

// File: tb/tb_wavegen_cfg_ctrl.sv
// Randomised and directed bench for wavegen_cfg_ctrl, covering the default
// timing and a RESET_CYCLES=1 / SETTLE_CYCLES=0 instance driven in parallel.
module tb_wavegen_cfg_ctrl;
    import wavegen_pkg::*;

    localparam int NC  = 64;
    localparam int W   = 16;
    localparam int CHW = 6;
    localparam int BW  = NC * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, wr_valid, wr_bcast, commit;
    logic [1:0]     wr_sel;
    logic [CHW-1:0] wr_chan;
    logic [W-1:0]   wr_data;

    logic          wr_ready_s [2];
    logic          gen_reset_s[2];
    logic          busy_s     [2];
    logic          dirty_s    [2];
    logic          done_s     [2];
    logic [BW-1:0] amps_s     [2];
    logic [BW-1:0] offsets_s  [2];
    logic [BW-1:0] phase_s    [2];

    wavegen_cfg_ctrl #(.NCHAN(NC), .WIDTH(W), .RESET_CYCLES(2), .SETTLE_CYCLES(8)) dut0 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready_s[0]),
        .wr_sel(wr_sel), .wr_chan(wr_chan), .wr_bcast(wr_bcast), .wr_data(wr_data),
        .commit(commit), .amps(amps_s[0]), .offsets(offsets_s[0]), .phasewords(phase_s[0]),
        .gen_reset(gen_reset_s[0]), .busy(busy_s[0]), .dirty(dirty_s[0]), .commit_done(done_s[0])
    );

    wavegen_cfg_ctrl #(.NCHAN(NC), .WIDTH(W), .RESET_CYCLES(1), .SETTLE_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready_s[1]),
        .wr_sel(wr_sel), .wr_chan(wr_chan), .wr_bcast(wr_bcast), .wr_data(wr_data),
        .commit(commit), .amps(amps_s[1]), .offsets(offsets_s[1]), .phasewords(phase_s[1]),
        .gen_reset(gen_reset_s[1]), .busy(busy_s[1]), .dirty(dirty_s[1]), .commit_done(done_s[1])
    );

    // Reference model: field contents plus "cycles since the last commit or reset edge".
    int         rc[2] = '{2, 1};
    int         sc[2] = '{8, 0};
    logic [W-1:0] m_shadow[2][3][NC];
    logic [W-1:0] m_active[2][3][NC];
    bit         m_dirty[2];
    int         m_k[2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit m_idle(input int d);
        return m_k[d] > rc[d] + sc[d];
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                for (int f = 0; f < 3; f++)
                    for (int c = 0; c < NC; c++) begin
                        m_shadow[d][f][c] = '0;
                        m_active[d][f][c] = '0;
                    end
                m_dirty[d] = 1'b0;
                m_k[d]     = 1;
            end else if (m_idle(d) && commit) begin
                for (int f = 0; f < 3; f++)
                    for (int c = 0; c < NC; c++)
                        m_active[d][f][c] = m_shadow[d][f][c];
                m_dirty[d] = 1'b0;
                m_k[d]     = 1;
            end else begin
                if (m_idle(d) && wr_valid && (wr_sel != 2'd3)) begin
                    for (int c = 0; c < NC; c++)
                        if (wr_bcast || (c == int'(wr_chan))) m_shadow[d][wr_sel][c] = wr_data;
                    m_dirty[d] = 1'b1;
                end
                if (m_k[d] < 100000) m_k[d]++;
            end
        end
    endtask

    task automatic check_bus(input string tag, input int d, input int f, input logic [BW-1:0] bus);
        int idx = 0;
        for (int c = NC - 1; c >= 0; c--)
            if (bus[c*W +: W] !== m_active[d][f][c]) idx = c;
        check_eq($sformatf("%s%0d[%0d]", tag, d, idx), bus[idx*W +: W], m_active[d][f][idx]);
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("gen_reset%0d", d), gen_reset_s[d], m_k[d] <= rc[d]);
            check_eq($sformatf("busy%0d", d), busy_s[d], m_k[d] <= rc[d] + sc[d]);
            check_eq($sformatf("commit_done%0d", d), done_s[d], m_k[d] == rc[d] + sc[d] + 1);
            check_eq($sformatf("dirty%0d", d), dirty_s[d], m_dirty[d]);
            check_bus("amps", d, 0, amps_s[d]);
            check_bus("offsets", d, 1, offsets_s[d]);
            check_bus("phase", d, 2, phase_s[d]);
        end
    endtask

    // One clock: check the combinational ready, clock, advance the model, check registers.
    task automatic step();
        #1;
        for (int d = 0; d < 2; d++)
            check_eq($sformatf("wr_ready%0d", d), wr_ready_s[d], m_idle(d) && !commit);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic do_write(input logic [1:0] sel, input int chan, input logic bc, input logic [W-1:0] data);
        wr_sel   = sel;
        wr_chan  = CHW'(chan);
        wr_bcast = bc;
        wr_data  = data;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; wr_valid = 1'b0; wr_bcast = 1'b0; commit = 1'b0;
        wr_sel = 2'd0; wr_chan = '0; wr_data = '0;

        // Power-up: three reset cycles, then release.
        @(posedge clk);
        model_edge();
        @(negedge clk);
        step(); step();
        reset = 1'b1;
        step();
        check_eq("pwr_genrst_1", gen_reset_s[0], 1'b1);
        step();
        check_eq("pwr_genrst_2", gen_reset_s[0], 1'b0);
        repeat (7) step();
        check_eq("pwr_busy_pre", busy_s[0], 1'b1);
        step();
        check_eq("pwr_busy_post", busy_s[0], 1'b0);
        check_eq("pwr_done", done_s[0], 1'b1);
        check_eq("pwr_amps_zero", amps_s[0] == '0, 1'b1);
        step();

        // Broadcast writes, then commit.
        do_write(SEL_AMP, 3, 1'b1, 16'h1000);
        do_write(SEL_PHASE, 9, 1'b1, 16'h0001);
        check_eq("bc_dirty", dirty_s[0], 1'b1);
        check_eq("bc_amps_pre", amps_s[0] == '0, 1'b1);
        commit = 1'b1;
        step();
        commit = 1'b0;
        check_eq("bc_amps_all", amps_s[0] == {64{16'h1000}}, 1'b1);
        check_eq("bc_phase_all", phase_s[0] == {64{16'h0001}}, 1'b1);
        check_eq("bc_dirty_clr", dirty_s[0], 1'b0);
        check_eq("bc_genrst_a", gen_reset_s[0], 1'b1);
        check_eq("sw_genrst1", gen_reset_s[1], 1'b1);
        step();
        check_eq("bc_genrst_b", gen_reset_s[0], 1'b1);
        check_eq("sw_done1", done_s[1], 1'b1);
        check_eq("sw_ready1", wr_ready_s[1], 1'b1);
        step();
        check_eq("bc_genrst_c", gen_reset_s[0], 1'b0);
        repeat (8) step();

        // Single-channel write to the top channel.
        do_write(SEL_OFFSET, 63, 1'b0, 16'hBEEF);
        commit = 1'b1;
        step();
        commit = 1'b0;
        check_eq("sc_off63", offsets_s[0][1023:1008], 16'hBEEF);
        check_eq("sc_off_rest", offsets_s[0][1007:0] == '0, 1'b1);
        repeat (10) step();

        // Reserved field: handshake only.
        do_write(2'd3, 5, 1'b1, 16'h5555);
        check_eq("rsvd_dirty", dirty_s[0], 1'b0);

        // Write and commit together, write held through the sequence.
        wr_valid = 1'b1; wr_sel = SEL_AMP; wr_chan = CHW'(7); wr_bcast = 1'b0; wr_data = 16'hABCD;
        commit = 1'b1;
        step();
        commit = 1'b0;
        check_eq("wc_dirty_a", dirty_s[0], 1'b0);
        repeat (10) step();
        check_eq("wc_dirty_b", dirty_s[0], 1'b0);
        step();
        check_eq("wc_dirty_c", dirty_s[0], 1'b1);
        wr_valid = 1'b0;
        step();

        // Reset while settling.
        commit = 1'b1;
        step();
        commit = 1'b0;
        repeat (4) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_eq("rs_genrst", gen_reset_s[0], 1'b1);
        check_eq("rs_busy", busy_s[0], 1'b1);
        check_eq("rs_done", done_s[0], 1'b0);
        check_eq("rs_amps_zero", amps_s[0] == '0, 1'b1);
        repeat (12) step();

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            reset    = ($urandom_range(0, 199) != 0);
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_sel   = 2'($urandom_range(0, 3));
            wr_chan  = CHW'($urandom_range(0, NC - 1));
            wr_bcast = ($urandom_range(0, 7) == 0);
            wr_data  = W'($urandom);
            commit   = ($urandom_range(0, 24) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wavegen_cfg_ctrl.md
Name: wavegen_cfg_ctrl

Overview:
- Configuration controller for the 64-channel summing wave generator (per-channel amplitude, offset and phase-word words feeding one summed 16-bit output).
- Accepts single-word or broadcast writes into a shadow bank over a valid/ready port.
- On commit, transfers the shadow bank atomically to the active buses driving the generator.
- Then sequences the generator's reset pulse and a settle window, so channels restart phase-aligned with the new settings.

Parameters:
- NCHAN, 64: number of generator channels.
- WIDTH, 16: bits per channel word.
- RESET_CYCLES, 2: cycles gen_reset is held high after a commit or power-up (minimum 1).
- SETTLE_CYCLES, 8: cycles after gen_reset falls before done/ready (generator pipeline depth; 0 allowed).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_sel  in  2  target field: 0 = amp, 1 = offset, 2 = phaseword, 3 = reserved (accepted, discarded).
- wr_chan  in  $clog2(NCHAN)  channel index.
- wr_bcast  in  1  write wr_data to all channels of wr_sel; wr_chan ignored.
- wr_data  in  WIDTH  write data.
- commit  in  1  request shadow-to-active transfer; level-sampled in IDLE.
- amps  out  NCHAN*WIDTH  active amplitudes; channel n at [WIDTH*n+WIDTH-1 : WIDTH*n].
- offsets  out  NCHAN*WIDTH  active offsets, same packing.
- phasewords  out  NCHAN*WIDTH  active phase words, same packing.
- gen_reset  out  1  active-high reset to the generator.
- busy  out  1  high in any state except IDLE.
- dirty  out  1  shadow written since last commit.
- commit_done  out  1  one-cycle pulse at end of the settle window.

Behaviour:
- States: IDLE, HOLD, SETTLE. Counter cnt is wide enough for max(RESET_CYCLES, SETTLE_CYCLES).
- Reset (reset == 0 at a clock edge):
  - All shadow and active words = 0; dirty = 0; commit_done = 0.
  - State = HOLD, cnt = 0, gen_reset = 1.
  - The generator is therefore reset at power-up; busy = 1 during reset.
  - Reset mid-operation aborts any sequence the same way and discards shadow contents.
- IDLE:
  - wr_ready = !commit (combinational). A commit takes priority, so a write and a commit are never accepted in the same cycle.
  - An accepted write updates the shadow at the next edge and sets dirty. A broadcast updates all NCHAN words of the field in one cycle.
  - If commit == 1:
    - At that edge, active <= shadow for all three fields simultaneously.
    - dirty <= 0; state <= HOLD; cnt <= 0; gen_reset <= 1.
  - A commit with dirty == 0 is still executed (re-sync pulse).
- HOLD:
  - gen_reset = 1 and wr_ready = 0.
  - After exactly RESET_CYCLES cycles in HOLD, gen_reset <= 0 and state <= SETTLE (or IDLE if SETTLE_CYCLES == 0, with commit_done pulsed).
- SETTLE:
  - gen_reset = 0 and wr_ready = 0.
  - After SETTLE_CYCLES cycles, state <= IDLE and commit_done = 1 for exactly one cycle, coincident with the first IDLE cycle.
  - commit is ignored outside IDLE; there is no queuing.
- Outputs are registered except wr_ready. Active buses change only on the commit edge, never mid-write.
- Commit latency to wr_ready high: RESET_CYCLES + SETTLE_CYCLES + 1 cycles.
- wr_sel == 3 is accepted (handshake completes) but writes nothing and does not set dirty.

Decomposition:
- Package wavegen_pkg:
  - NCHAN / WIDTH defaults.
  - Field-select constants SEL_AMP = 0, SEL_OFFSET = 1, SEL_PHASE = 2.
  - State encoding.
- Sub-module wavegen_cfg_bank: one field's shadow and active register array, with write/broadcast/commit inputs. Instantiated three times.
- The FSM and handshake stay in the top module.

Test Plan:
- Power-up: hold reset = 0 for 3 cycles, then release.
  - gen_reset = 1 for 2 cycles after release.
  - busy then falls 8 cycles later, with a commit_done pulse.
  - All buses = 0.
- Broadcast: sel = amp, data 16'h1000, broadcast; sel = phase, data 16'h0001, broadcast; then commit.
  - Before commit: amps and phasewords stay 0.
  - Commit edge: amps = {64{16'h1000}}, phasewords = {64{16'h0001}}.
  - gen_reset high for exactly 2 cycles; dirty 1 → 0.
- Single write: chan 63, sel = offset, data 16'hBEEF, then commit.
  - offsets[1023:1008] = BEEF; all other offset words unchanged.
  - sel = 3 write leaves every bus and dirty unchanged.
- Write and commit asserted in the same IDLE cycle: wr_ready = 0, write not taken, commit executes.
  - Writes held valid through HOLD/SETTLE are accepted only on the first IDLE cycle.
- Reset asserted in SETTLE: next cycle state = HOLD, gen_reset = 1, buses = 0, dirty = 0, no commit_done pulse.
- Parameter sweep RESET_CYCLES = 1, SETTLE_CYCLES = 0: commit → gen_reset for 1 cycle, commit_done on the following cycle, wr_ready high 2 cycles after commit.
